battleship_controller: RTL and testbench
========================================

Name: battleship_controller

Overview:
- Game-state writer for the battleship design. Consumes debounced button levels and owns both game boards, both ship counts and the turn bit.
- The VGA and SSD blocks only read that state.
- Runs a placement phase (each player places NUM_SHIPS single-cell ships), then alternating fire turns until one fleet is sunk.

Parameters:
- GRID_DIM, 5, cells per board side; boards are GRID_DIM x GRID_DIM.
- CELL_W, 3, bits per cell code.
- NUM_SHIPS, 5, ships per player; must fit in 3 bits.

Ports:
- clk  in  1  master clock
- rst  in  1  synchronous active-high reset
- btnC  in  1  debounced commit (place/fire) level
- btnU  in  1  debounced cursor-up level
- btnD  in  1  debounced cursor-down level
- btnL  in  1  debounced cursor-left level
- btnR  in  1  debounced cursor-right level
- p1_board  out  GRID_DIM*GRID_DIM*CELL_W  player 1 board; cell i at [i*CELL_W +: CELL_W], i = y*GRID_DIM + x
- p2_board  out  same  player 2 board
- p1_ships  out  3  player 1 ships remaining
- p2_ships  out  3  player 2 ships remaining
- turn  out  1  0 = player 1 acting, 1 = player 2 acting
- cursor_x  out  3  cursor column, 0..GRID_DIM-1
- cursor_y  out  3  cursor row, 0..GRID_DIM-1
- game_over  out  1  high in DONE
- winner  out  1  valid when game_over: 0 = P1, 1 = P2

Behaviour:
- One clock and one reset: rst is synchronous and active-high; all state is in the clk domain.
- Reset values:
  - all board cells EMPTY
  - p1_ships = p2_ships = NUM_SHIPS
  - turn = 0
  - cursor = (0,0)
  - placed count = 0
  - state = P1_PLACE
  - game_over = 0, winner = 0
  - btn_prev registers = all 1s, so a button still held when rst drops (rst is driven by btnC plus switches) does not fire.
- Edge detection:
  - event = level & ~prev.
  - prev updates every cycle.
  - Action takes effect at the same clock edge that first samples the level high; the output changes 1 cycle after the press.
  - A held button produces exactly one event.
- Simultaneous events in one cycle: commit beats moves; among moves U > D > L > R; only one action per cycle.
- Cursor:
  - U decrements y, D increments y, L decrements x, R increments x.
  - Moves wrap: 0 -> GRID_DIM-1 and GRID_DIM-1 -> 0.
  - Cursor resets to (0,0) on every state change.
- Cell codes: EMPTY = 0, SHIP = 1, MISS = 2, HIT = 3; codes 4-7 are never written.
- P1_PLACE (turn = 0):
  - Commit on an EMPTY cell of p1_board writes SHIP and increments placed.
  - Commit on a SHIP cell is ignored.
  - When placed reaches NUM_SHIPS: clear placed, go to P2_PLACE.
- P2_PLACE (turn = 1): same rules on p2_board; after the last ship go to P1_FIRE.
- P1_FIRE (turn = 0): targets p2_board.
  - SHIP: write HIT, decrement p2_ships.
  - EMPTY: write MISS.
  - MISS or HIT: ignored; no state or turn change.
  - After a valid shot: if p2_ships becomes 0, go to DONE with winner = 0; otherwise go to P2_FIRE.
- P2_FIRE (turn = 1): mirror of P1_FIRE on p1_board; a win sets winner = 1.
- DONE:
  - game_over = 1, all inputs ignored, boards frozen.
  - turn holds the last shooter.
  - Exit only via rst.
- Ship counters never underflow; a decrement happens only on a SHIP-to-HIT write.
- rst asserted mid-game restores all reset values on the next edge regardless of state.

Decomposition:
- Shared package/include (battleship definitions):
  - cell codes EMPTY/SHIP/MISS/HIT
  - GRID_DIM, CELL_W, NUM_SHIPS
  - BOARD_SIZE = GRID_DIM*GRID_DIM*CELL_W
  - state encodings P1_PLACE, P2_PLACE, P1_FIRE, P2_FIRE, DONE
- One natural sub-module: btn_edge. It takes a 5-bit level vector plus clk/rst, has reset-to-ones prev registers, and outputs a 5-bit one-cycle pulse vector. Instantiated once.
- Everything else (FSM, cursor, board write, counters) stays in battleship_controller.

Test Plan:
- Reset, then tap R twice and D once -> cursor = (2,1). Then tap L three times -> cursor_x wraps 2 -> 1 -> 0 -> 4.
- Hold btnC through rst deassertion -> no cell written. Also press U and C in the same cycle -> commit only, cursor unchanged.
- P1 places at cells 0,1,2,3,4, with a repeat commit on cell 0 ignored -> p1_board bits [14:0] = 001 in each cell, state P2_PLACE, turn = 1, cursor = (0,0).
- After both placements (P2 at cells 20..24): P1 fires at (0,4) -> p2 cell 20 = HIT, p2_ships = 4, turn = 1. P2 fires at (4,4) -> p1 cell 24 = MISS, p1_ships = 5, turn = 0.
- P1 re-fires on the HIT cell 20 -> no change, turn stays 0.
- P1 sinks P2's remaining 4 ships, with P2 missing in between -> p2_ships = 0, game_over = 1, winner = 0. Further presses produce no board change. rst -> all boards zero, ships = 5, state P1_PLACE.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared battleship definitions: board geometry, cell codes, controller states
// and the cell-address helper used by every block that touches a board.
package battleship_pkg;

  localparam int GRID_DIM   = 5;
  localparam int CELL_W     = 3;
  localparam int NUM_SHIPS  = 5;
  localparam int NUM_CELLS  = GRID_DIM * GRID_DIM;
  localparam int BOARD_SIZE = NUM_CELLS * CELL_W;
  localparam int LSB_W      = $clog2(BOARD_SIZE);

  localparam logic [2:0] EMPTY = 3'd0;
  localparam logic [2:0] SHIP  = 3'd1;
  localparam logic [2:0] MISS  = 3'd2;
  localparam logic [2:0] HIT   = 3'd3;

  localparam logic [2:0] P1_PLACE = 3'd0;
  localparam logic [2:0] P2_PLACE = 3'd1;
  localparam logic [2:0] P1_FIRE  = 3'd2;
  localparam logic [2:0] P2_FIRE  = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam logic [2:0] MAX_COORD  = 3'(GRID_DIM - 1);
  localparam logic [2:0] SHIPS_INIT = 3'(NUM_SHIPS);

  // Button bundle in the same bit order as the level vector fed to btn_edge.
  typedef struct packed {
    logic c;
    logic u;
    logic d;
    logic l;
    logic r;
  } btn_t;

  function automatic logic [LSB_W-1:0] cell_lsb(input logic [2:0] x,
                                                 input logic [2:0] y);
    return LSB_W'((int'(y) * GRID_DIM + int'(x)) * CELL_W);
  endfunction

endpackage

// File: rtl/battleship_controller_btn_edge.sv
// Rising-edge detector for the five debounced buttons; prev resets to ones so
// a button held across reset release never produces an event.
module btn_edge
  import battleship_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] level,
  output logic [4:0] pulse
);

  logic [4:0] prev;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) prev <= '1;
    else     prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/battleship_controller.sv
// Game-state writer: placement phase, alternating fire turns, and the final
// DONE state; owns both boards, ship counts, cursor and turn.
module battleship_controller
  import battleship_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btnC,
  input  logic                  btnU,
  input  logic                  btnD,
  input  logic                  btnL,
  input  logic                  btnR,
  output logic [BOARD_SIZE-1:0] p1_board,
  output logic [BOARD_SIZE-1:0] p2_board,
  output logic [2:0]            p1_ships,
  output logic [2:0]            p2_ships,
  output logic                  turn,
  output logic [2:0]            cursor_x,
  output logic [2:0]            cursor_y,
  output logic                  game_over,
  output logic                  winner
);

  logic [2:0]       state;
  logic [2:0]       placed;
  logic [4:0]       pulse;
  btn_t             ev;
  logic [LSB_W-1:0] lsb;
  logic [2:0]       p1_cell;
  logic [2:0]       p2_cell;

  btn_edge u_btn_edge (
    .clk   (clk),
    .rst   (rst),
    .level ({btnC, btnU, btnD, btnL, btnR}),
    .pulse (pulse)
  );

  assign ev = btn_t'(pulse);

  // NOTE: every always_comb output gets a value on every path, so no latches.
  always_comb begin
    lsb     = cell_lsb(cursor_x, cursor_y);
    p1_cell = p1_board[lsb +: CELL_W];
    p2_cell = p2_board[lsb +: CELL_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: boards are flop arrays read live by the display, so they reset.
      p1_board  <= '0;
      p2_board  <= '0;
      p1_ships  <= SHIPS_INIT;
      p2_ships  <= SHIPS_INIT;
      turn      <= 1'b0;
      cursor_x  <= '0;
      cursor_y  <= '0;
      placed    <= '0;
      state     <= P1_PLACE;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else if (state != DONE) begin
      if (ev.c) begin
        case (state)
          P1_PLACE: if (p1_cell == EMPTY) begin
            p1_board[lsb +: CELL_W] <= SHIP;
            if (placed == SHIPS_INIT - 3'd1) begin
              placed   <= '0;
              state    <= P2_PLACE;
              turn     <= 1'b1;
              cursor_x <= '0;
              cursor_y <= '0;
            end else begin
              placed <= placed + 3'd1;
            end
          end
          P2_PLACE: if (p2_cell == EMPTY) begin
            p2_board[lsb +: CELL_W] <= SHIP;
            if (placed == SHIPS_INIT - 3'd1) begin
              placed   <= '0;
              state    <= P1_FIRE;
              turn     <= 1'b0;
              cursor_x <= '0;
              cursor_y <= '0;
            end else begin
              placed <= placed + 3'd1;
            end
          end
          P1_FIRE: if (p2_cell == SHIP || p2_cell == EMPTY) begin
            p2_board[lsb +: CELL_W] <= (p2_cell == SHIP) ? HIT : MISS;
            cursor_x <= '0;
            cursor_y <= '0;
            if (p2_cell == SHIP) p2_ships <= p2_ships - 3'd1;
            if (p2_cell == SHIP && p2_ships == 3'd1) begin
              state     <= DONE;
              game_over <= 1'b1;
              winner    <= 1'b0;
            end else begin
              state <= P2_FIRE;
              turn  <= 1'b1;
            end
          end
          P2_FIRE: if (p1_cell == SHIP || p1_cell == EMPTY) begin
            p1_board[lsb +: CELL_W] <= (p1_cell == SHIP) ? HIT : MISS;
            cursor_x <= '0;
            cursor_y <= '0;
            if (p1_cell == SHIP) p1_ships <= p1_ships - 3'd1;
            if (p1_cell == SHIP && p1_ships == 3'd1) begin
              state     <= DONE;
              game_over <= 1'b1;
              winner    <= 1'b1;
            end else begin
              state <= P1_FIRE;
              turn  <= 1'b0;
            end
          end
          default: state <= state;
        endcase
      end else if (ev.u) begin
        cursor_y <= (cursor_y == 3'd0) ? MAX_COORD : cursor_y - 3'd1;
      end else if (ev.d) begin
        cursor_y <= (cursor_y == MAX_COORD) ? 3'd0 : cursor_y + 3'd1;
      end else if (ev.l) begin
        cursor_x <= (cursor_x == 3'd0) ? MAX_COORD : cursor_x - 3'd1;
      end else if (ev.r) begin
        cursor_x <= (cursor_x == MAX_COORD) ? 3'd0 : cursor_x + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_battleship_controller.sv
// Directed bench for battleship_controller: cursor wrap, edge detection,
// placement, a full firing game to a P1 win, DONE freeze and reset.
module tb_battleship_controller;
  import battleship_pkg::*;

  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_U = 5'b01000;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_L = 5'b00010;
  localparam logic [4:0] B_R = 5'b00001;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [4:0]            btns = '0;
  logic [BOARD_SIZE-1:0] p1_board, p2_board;
  logic [2:0]            p1_ships, p2_ships, cursor_x, cursor_y;
  logic                  turn, game_over, winner;

  logic [BOARD_SIZE-1:0] exp1, exp2;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  battleship_controller dut (
    .clk       (clk),
    .rst       (rst),
    .btnC      (btns[4]),
    .btnU      (btns[3]),
    .btnD      (btns[2]),
    .btnL      (btns[1]),
    .btnR      (btns[0]),
    .p1_board  (p1_board),
    .p2_board  (p2_board),
    .p1_ships  (p1_ships),
    .p2_ships  (p2_ships),
    .turn      (turn),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .game_over (game_over),
    .winner    (winner)
  );

  task automatic check(input string tag, input logic [79:0] got,
                       input logic [79:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Press for one cycle, release, then let prev see the low level.
  task automatic tap(input logic [4:0] mask);
    @(negedge clk) btns = mask;
    @(negedge clk) btns = '0;
    @(negedge clk);
  endtask

  // Navigate from the origin, which every state change returns the cursor to.
  task automatic goto(input int x, input int y);
    repeat (y) tap(B_D);
    repeat (x) tap(B_R);
  endtask

  initial begin
    exp1 = '0;
    exp2 = '0;

    // Hold commit across reset release: no write may happen.
    repeat (2) @(negedge clk);
    btns = B_C;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("held_c_no_write", p1_board, '0);
    btns = '0;
    @(negedge clk);
    check("rst_p1_board", p1_board, '0);
    check("rst_p2_board", p2_board, '0);
    check("rst_p1_ships", p1_ships, 5);
    check("rst_p2_ships", p2_ships, 5);
    check("rst_turn", turn, 0);
    check("rst_cursor", {cursor_x, cursor_y}, 6'o00);
    check("rst_game_over", {game_over, winner}, 2'b00);

    // Held R counts once, then R, D.
    @(negedge clk) btns = B_R;
    repeat (4) @(negedge clk);
    btns = '0;
    @(negedge clk);
    check("held_r_once", cursor_x, 1);
    tap(B_R);
    tap(B_D);
    check("cursor_2_1", {cursor_x, cursor_y}, 6'o21);
    tap(B_L);
    check("left_x1", cursor_x, 1);
    tap(B_L);
    check("left_x0", cursor_x, 0);
    tap(B_L);
    check("left_wrap_x4", {cursor_x, cursor_y}, 6'o41);
    tap(B_R);
    check("right_wrap_x0", cursor_x, 0);
    tap(B_U);
    check("back_to_origin", {cursor_x, cursor_y}, 6'o00);

    // Commit beats a simultaneous up press.
    tap(B_C | B_U);
    exp1[0 +: 3] = SHIP;
    check("c_beats_u_cursor", {cursor_x, cursor_y}, 6'o00);
    check("c_beats_u_board", p1_board, exp1);
    tap(B_C);
    check("repeat_place_ignored", p1_board, exp1);
    for (int i = 1; i < 5; i++) begin
      tap(B_R);
      tap(B_C);
      exp1[i*3 +: 3] = SHIP;
      if (i == 3) check("p1_still_placing", turn, 0);
    end
    check("p1_placed_board", p1_board, 75'h1249);
    check("p2_place_turn", turn, 1);
    check("p2_place_cursor", {cursor_x, cursor_y}, 6'o00);

    // P2 places on row 4 (cells 20..24); up from row 0 wraps to row 4.
    tap(B_U);
    check("up_wrap_y4", cursor_y, 4);
    tap(B_C);
    for (int i = 1; i < 5; i++) begin
      tap(B_R);
      tap(B_C);
    end
    for (int i = 20; i < 25; i++) exp2[i*3 +: 3] = SHIP;
    check("p2_placed_board", p2_board, exp2);
    check("p1_fire_turn", turn, 0);

    // P1 hits cell 20.
    goto(0, 4);
    tap(B_C);
    exp2[60 +: 3] = HIT;
    check("p1_hit20_board", p2_board, exp2);
    check("p1_hit20_ships", p2_ships, 4);
    check("p1_hit20_turn", turn, 1);
    check("p1_hit20_cursor", {cursor_x, cursor_y}, 6'o00);

    // P2 misses cell 24.
    goto(4, 4);
    tap(B_C);
    exp1[72 +: 3] = MISS;
    check("p2_miss24_board", p1_board, exp1);
    check("p2_miss24_ships", p1_ships, 5);
    check("p2_miss24_turn", turn, 0);

    // P1 re-fires on the HIT cell: nothing changes.
    goto(0, 4);
    tap(B_C);
    check("refire_board", p2_board, exp2);
    check("refire_turn", turn, 0);
    check("refire_ships", p2_ships, 4);

    tap(B_R);
    tap(B_C);
    exp2[63 +: 3] = HIT;
    check("p1_hit21_ships", p2_ships, 3);
    check("p1_hit21_turn", turn, 1);

    goto(3, 4); tap(B_C); exp1[69 +: 3] = MISS;
    goto(2, 4); tap(B_C); exp2[66 +: 3] = HIT;
    check("p1_hit22_ships", p2_ships, 2);
    goto(2, 4); tap(B_C); exp1[66 +: 3] = MISS;
    goto(3, 4); tap(B_C); exp2[69 +: 3] = HIT;
    goto(1, 4); tap(B_C); exp1[63 +: 3] = MISS;
    check("p2_misses_board", p1_board, exp1);
    check("before_last_turn", turn, 0);
    goto(4, 4); tap(B_C); exp2[72 +: 3] = HIT;
    check("sunk_board", p2_board, exp2);
    check("sunk_ships", p2_ships, 0);
    check("done_flags", {game_over, winner}, 2'b10);
    check("done_turn", turn, 0);

    // DONE ignores everything.
    tap(B_C);
    tap(B_R);
    tap(B_C | B_D);
    check("done_p1_frozen", p1_board, exp1);
    check("done_p2_frozen", p2_board, exp2);
    check("done_cursor", {cursor_x, cursor_y}, 6'o00);
    check("done_still_over", game_over, 1);

    // Mid-game reset returns to P1_PLACE.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("rerst_boards", {p1_board[74:0], p2_board[4:0]}, '0);
    check("rerst_p2_board", p2_board, '0);
    check("rerst_ships", {p1_ships, p2_ships}, 6'o55);
    check("rerst_flags", {game_over, winner, turn}, 3'b000);
    tap(B_C);
    check("rerst_places_p1", p1_board, 75'h1);
    check("rerst_turn", turn, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
